threeadder_ctrl: RTL



---
 rtl/threeadder_pkg.sv | 23 ++
 rtl/threeadder_timeout.sv | 31 +++
 rtl/threeadder_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/threeadder_pkg.sv
// Shared types and constants for the three-operand adder sequencer.
// Both the controller and its timeout counter import this package.
package threeadder_pkg;

   localparam int DEFAULT_W       = 8;
   localparam int DEFAULT_TIMEOUT = 15;

   typedef enum logic [2:0] {
      LOAD_A = 3'd0,
      LOAD_B,
      LOAD_C,
      START,
      WAIT,
      OUT_LO,
      OUT_HI
   } state_t;

   // Three W-bit operands sum to at most 3*(2^W-1), which always fits in W+2 bits.
   function automatic int result_width(input int w);
      return w + 2;
   endfunction

endpackage

// File: rtl/threeadder_timeout.sv
// Wait-for-done cycle counter: cleared outside the start/wait window,
// saturates at TIMEOUT and flags expiry.
module threeadder_timeout
   import threeadder_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && !o_expired) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_expired = (r_count == CW'(TIMEOUT));

endmodule

// File: rtl/threeadder_ctrl.sv
// Sequencer: gathers a, b, c from one stream, starts the adder, waits for done
// (with timeout) and returns the W+2 bit sum as a low beat and a high beat.
module threeadder_ctrl
   import threeadder_pkg::*;
#(
   parameter int W       = DEFAULT_W,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [W-1:0]   in_data,
   input  logic           in_valid,
   output logic           in_ready,
   output logic [W-1:0]   add_a,
   output logic [W-1:0]   add_b,
   output logic [W-1:0]   add_c,
   output logic           add_start,
   input  logic           add_done,
   input  logic [W+1:0]   add_sum,
   output logic [W-1:0]   out_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           out_last,
   output logic           busy,
   output logic           err,
   output logic [2:0]     o_dbg_state
);

   localparam int RW = result_width(W);

   // Handshakes: a beat moves on a rising edge where valid && ready are both high;
   // ready/valid are registered so no input reaches an output in the same cycle.

   state_t          r_state;
   state_t          w_next;
   logic            r_in_ready;
   logic            r_add_start;
   logic            r_out_valid;
   logic            r_out_last;
   logic            r_busy;
   logic            r_err;
   logic [W-1:0]    r_add_a;
   logic [W-1:0]    r_add_b;
   logic [W-1:0]    r_add_c;
   logic [W-1:0]    r_out_data;
   logic [RW-1:0]   r_result;
   logic            w_in_fire;
   logic            w_out_fire;
   logic            w_expired;
   logic            w_cnt_en;
   logic            w_err;
   logic [W-1:0]    w_out_data;

   assign w_in_fire  = in_valid && r_in_ready;
   assign w_out_fire = r_out_valid && out_ready;
   assign w_cnt_en   = (r_state == START) || (r_state == WAIT);

   threeadder_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk       (clk),
      .reset     (reset),
      .i_clear   (!w_cnt_en),
      .i_enable  (w_cnt_en),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= LOAD_A;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_err      = r_err;
      w_out_data = r_out_data;
      case (r_state)
         LOAD_A: if (w_in_fire) begin
            w_next = LOAD_B;
            w_err  = 1'b0;
         end
         LOAD_B: if (w_in_fire) w_next = LOAD_C;
         LOAD_C: if (w_in_fire) w_next = START;
         START:  w_next = WAIT;
         // A done arriving on the expiry cycle still wins over the timeout.
         WAIT: begin
            if (add_done) begin
               w_next     = OUT_LO;
               w_out_data = add_sum[W-1:0];
            end else if (w_expired) begin
               w_next = LOAD_A;
               w_err  = 1'b1;
            end
         end
         OUT_LO: begin
            if (w_out_fire) begin
               w_next     = OUT_HI;
               w_out_data = W'(r_result[RW-1:W]);
            end else begin
               w_out_data = r_result[W-1:0];
            end
         end
         OUT_HI: if (w_out_fire) begin
            w_next     = LOAD_A;
            w_out_data = '0;
         end
         default: w_next = LOAD_A;
      endcase
   end

   // Status outputs are decoded from the next state so they line up with r_state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_in_ready  <= 1'b0;
         r_add_start <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_busy      <= 1'b0;
         r_err       <= 1'b0;
         r_add_a     <= '0;
         r_add_b     <= '0;
         r_add_c     <= '0;
         r_out_data  <= '0;
         r_result    <= '0;
      end else begin
         r_in_ready  <= (w_next == LOAD_A) || (w_next == LOAD_B) || (w_next == LOAD_C);
         r_add_start <= (w_next == START);
         r_out_valid <= (w_next == OUT_LO) || (w_next == OUT_HI);
         r_out_last  <= (w_next == OUT_HI);
         r_busy      <= (w_next != LOAD_A);
         r_err       <= w_err;
         r_out_data  <= w_out_data;
         if (w_in_fire && (r_state == LOAD_A)) r_add_a <= in_data;
         if (w_in_fire && (r_state == LOAD_B)) r_add_b <= in_data;
         if (w_in_fire && (r_state == LOAD_C)) r_add_c <= in_data;
         if ((r_state == WAIT) && add_done) r_result <= add_sum;
      end
   end

   assign in_ready    = r_in_ready;
   assign add_a       = r_add_a;
   assign add_b       = r_add_b;
   assign add_c       = r_add_c;
   assign add_start   = r_add_start;
   assign out_data    = r_out_data;
   assign out_valid   = r_out_valid;
   assign out_last    = r_out_last;
   assign busy        = r_busy;
   assign err         = r_err;
   assign o_dbg_state = r_state;

endmodule
